// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one instruction-memory read at a
// time, and drives the IF/ID register with MIPS delay-slot branch handling.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_addr,
  output logic        rom_en,
  output logic [31:0] rom_addr,
  input  logic        rom_ready,
  input  logic        rom_rvalid,
  input  logic [31:0] rom_rdata,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL, S_DROP} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inflight_pc;
  logic [31:0] r_buf_pc;
  logic [31:0] r_buf_inst;
  logic        r_redirect_pending;
  logic [31:0] r_redirect_target;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_inst;
  logic        r_id_valid;

  logic        w_req_fire;
  logic        w_deliver_mem;
  logic        w_deliver_buf;
  logic        w_branch_take;
  logic        w_outstanding;
  logic [31:0] w_seq_pc;
  logic [31:0] w_slot_pc;
  logic [31:0] w_after_slot_pc;

  assign w_req_fire      = (r_state == S_REQ) && rom_ready;
  assign w_deliver_mem   = (r_state == S_WAIT) && rom_rvalid && !stall;
  assign w_deliver_buf   = (r_state == S_FULL) && !stall;
  assign w_branch_take   = branch_flag && r_id_valid && !stall;
  assign w_seq_pc        = r_redirect_pending ? r_redirect_target : r_pc + 32'd4;
  assign w_slot_pc       = r_id_pc + 32'd4;
  assign w_after_slot_pc = r_id_pc + 32'd8;

  // A response still owed by memory after this edge must be swallowed in DROP.
  assign w_outstanding = w_req_fire ||
                         (((r_state == S_WAIT) || (r_state == S_DROP)) && !rom_rvalid);

  assign rom_en   = (r_state == S_REQ) && !rst;
  assign rom_addr = r_pc;
  assign id_pc    = r_id_pc;
  assign id_inst  = r_id_inst;
  assign id_valid = r_id_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state            <= S_REQ;
      r_pc               <= RESET_PC;
      r_inflight_pc      <= RESET_PC;
      r_buf_pc           <= 32'd0;
      r_buf_inst         <= 32'd0;
      r_redirect_pending <= 1'b0;
      r_redirect_target  <= 32'd0;
      r_id_pc            <= 32'd0;
      r_id_inst          <= 32'd0;
      r_id_valid         <= 1'b0;
    end else if (flush) begin
      r_pc               <= flush_pc;
      r_redirect_pending <= 1'b0;
      r_id_pc            <= 32'd0;
      r_id_inst          <= 32'd0;
      r_id_valid         <= 1'b0;
      r_state            <= w_outstanding ? S_DROP : S_REQ;
    end else begin
      case (r_state)
        S_REQ: begin
          if (rom_ready) begin
            r_inflight_pc      <= r_pc;
            r_pc               <= w_seq_pc;
            r_redirect_pending <= 1'b0;
            r_state            <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (rom_rvalid) begin
            if (stall) begin
              r_buf_pc   <= r_inflight_pc;
              r_buf_inst <= rom_rdata;
              r_state    <= S_FULL;
            end else begin
              r_state <= S_REQ;
            end
          end
        end
        S_FULL: begin
          if (!stall) r_state <= S_REQ;
        end
        S_DROP: begin
          if (rom_rvalid) r_state <= S_REQ;
        end
        default: r_state <= S_REQ;
      endcase

      if (w_deliver_mem) begin
        r_id_pc    <= r_inflight_pc;
        r_id_inst  <= rom_rdata;
        r_id_valid <= 1'b1;
      end else if (w_deliver_buf) begin
        r_id_pc    <= r_buf_pc;
        r_id_inst  <= r_buf_inst;
        r_id_valid <= 1'b1;
      end else if (!stall) begin
        r_id_pc    <= 32'd0;
        r_id_inst  <= 32'd0;
        r_id_valid <= 1'b0;
      end

      // Delay slot is always fetched; only the address after it is redirected.
      if (w_branch_take) begin
        if (r_pc == w_slot_pc) begin
          if (w_req_fire) begin
            r_pc <= branch_addr;
          end else begin
            r_redirect_pending <= 1'b1;
            r_redirect_target  <= branch_addr;
          end
        end else if (r_pc == w_after_slot_pc) begin
          r_pc <= branch_addr;
        end
      end
    end
  end

endmodule
